// File: rtl/ex_alu_arbiter.sv
// ex_alu_arbiter
// Shares one EX-stage ALU between NREQ requesters. Arbitration is round-robin.
// Every port uses a valid/ready handshake. The result is held in a one-entry
// registered buffer, so a result appears one cycle after its handshake.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   TAGW  width of the opaque per-request tag
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   per-requester handshake (NREQ bits each)
//   req_op            5-bit ALUop per requester, packed
//   req_a, req_b      32-bit operands per requester, packed
//   req_tag           TAGW-bit tag per requester, packed
//   rsp_valid/ready   result buffer handshake
//   rsp_id            index of the requester that produced the result
//   rsp_op            ALUop of the result
//   rsp_tag           tag of the result
//   rsp_data          ALU result
//
// Optional feature:
//   Define EX_ALU_ARB_PERF_EN to add two sets of counters:
//     perf_grant_cnt  per-requester count of grants
//     perf_stall_cnt  cycles stalled by consumer backpressure

module ex_alu_arbiter #(
    parameter int NREQ = 2,
    parameter int TAGW = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [5*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [TAGW*NREQ-1:0] req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [4:0]           rsp_op,
    output logic [TAGW-1:0]      rsp_tag,
    output logic [31:0]          rsp_data
`ifdef EX_ALU_ARB_PERF_EN
    ,
    output logic [32*NREQ-1:0]   perf_grant_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [IDW-1:0]  ptr, ptr_next;
    logic [IDW-1:0]  win;
    logic            found;
    logic            can_accept;
    logic            grant;
    logic [4:0]      sel_op;
    logic [31:0]     sel_a, sel_b;
    logic [TAGW-1:0] sel_tag;
    logic [31:0]     alu_res;

    assign rsp_valid = (state == FULL);

    // Round-robin search starting at ptr.
    // The buffer can take a new result when it is empty. It can also take
    // one when it is full and being drained in this same cycle, which keeps
    // throughput at one result per cycle.
    // Reset is folded in here so that nothing is granted in the reset cycle.
    always_comb begin
        int idx;
        req_ready  = '0;
        win        = '0;
        found      = 1'b0;
        idx        = 0;
        can_accept = !rst && ((state == EMPTY) || rsp_ready);
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        if (found && can_accept) req_ready[win] = 1'b1;
    end

    // req_ready is only ever set for a valid winner, so any ready bit means a handshake
    assign grant = |req_ready;

    // Pick the winner's fields out of the packed request buses
    always_comb begin
        sel_op  = req_op[int'(win)*5 +: 5];
        sel_a   = req_a[int'(win)*32 +: 32];
        sel_b   = req_b[int'(win)*32 +: 32];
        sel_tag = req_tag[int'(win)*TAGW +: TAGW];
    end

    // ALU decode.
    // It uses the same 5-bit encoding as the EX stage.
    // An unknown op returns zero and is still a normal response.
    always_comb begin
        alu_res = 32'd0;
        case (sel_op)
            5'b10001, 5'b10100, 5'b10101,
            5'b01100, 5'b01101: alu_res = sel_a + sel_b;
            5'b01110:           alu_res = sel_a - sel_b;
            5'b01000:           alu_res = sel_a << sel_b[4:0];
            5'b01001:           alu_res = sel_a >> sel_b[4:0];
            5'b00110:           alu_res = sel_a ^ sel_b;
            5'b00101:           alu_res = sel_a | sel_b;
            5'b00100:           alu_res = sel_a & sel_b;
            default:            alu_res = 32'd0;
        endcase
    end

    // Next state and pointer.
    // A grant always leaves the buffer full, even when the old result drains
    // in the same cycle.
    // A drain without a grant empties the buffer and leaves the pointer alone.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        if (grant) begin
            state_next = FULL;
            ptr_next   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        end else if ((state == FULL) && rsp_ready) begin
            state_next = EMPTY;
        end
    end

    // State register and result buffer.
    // The buffer only loads on a grant, so it holds steady under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= '0;
            rsp_id   <= '0;
            rsp_op   <= '0;
            rsp_tag  <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            if (grant) begin
                rsp_id   <= win;
                rsp_op   <= sel_op;
                rsp_tag  <= sel_tag;
                rsp_data <= alu_res;
            end
        end
    end

`ifdef EX_ALU_ARB_PERF_EN
    // Performance counters. They wrap naturally at 2^32.
    // A stall is a cycle where the buffer is full, the consumer is not
    // taking it, and someone is waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) perf_grant_cnt[32*i +: 32] <= perf_grant_cnt[32*i +: 32] + 32'd1;
            end
            if ((state == FULL) && !rsp_ready && (|req_valid)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_alu_arbiter.sv
// tb_ex_alu_arbiter
// Self-checking bench for ex_alu_arbiter with NREQ=2 and TAGW=4.
// A reference model tracks the buffer occupancy and the round-robin pointer.
// Expected results are queued when a handshake is driven. They are compared
// against rsp_* for as long as the buffer is full.

module tb_ex_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [4:0]  op [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [3:0]  tag [2];
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [4:0]  rsp_op;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_data;
`ifdef EX_ALU_ARB_PERF_EN
    logic [63:0] perf_grant_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    typedef struct {
        logic [0:0]  id;
        logic [4:0]  op;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          m_ptr;
    bit          just_reset;
    int unsigned m_grants[2];
    int unsigned m_stalls;
    int          compared;
    int          mismatched;

    ex_alu_arbiter #(.NREQ(2), .TAGW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    ({op[1], op[0]}),
        .req_a     ({a[1], a[0]}),
        .req_b     ({b[1], b[0]}),
        .req_tag   ({tag[1], tag[0]}),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_op    (rsp_op),
        .rsp_tag   (rsp_tag),
        .rsp_data  (rsp_data)
`ifdef EX_ALU_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] refAlu(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            5'b10001, 5'b10100, 5'b10101, 5'b01100, 5'b01101: return x + y;
            5'b01110: return x - y;
            5'b01000: return x << y[4:0];
            5'b01001: return x >> y[4:0];
            5'b00110: return x ^ y;
            5'b00101: return x | y;
            5'b00100: return x & y;
            default:  return 32'd0;
        endcase
    endfunction

    // Called mid-cycle, once inputs have settled.
    // It checks the outputs against the model, then advances the model to
    // what the next clock edge should produce.
    task automatic scoreCycle();
        int       win;
        bit       can;
        bit       full;
        logic [1:0] exp_ready;
        exp_t     e;
        full = (exp_q.size() != 0);
        can  = !rst && (!full || rsp_ready);
        win  = -1;
        if (can) begin
            for (int k = 0; k < 2; k++) begin
                int idx;
                idx = (m_ptr + k) % 2;
                if (win < 0 && req_valid[idx]) win = idx;
            end
        end
        exp_ready = (win >= 0) ? 2'(1 << win) : 2'b00;
        checkOutput("req_ready", req_ready, exp_ready);
        checkOutput("rsp_valid", rsp_valid, full);
        if (full) begin
            checkOutput("rsp_id", rsp_id, exp_q[0].id);
            checkOutput("rsp_op", rsp_op, exp_q[0].op);
            checkOutput("rsp_tag", rsp_tag, exp_q[0].tag);
            checkOutput("rsp_data", rsp_data, exp_q[0].data);
        end
        if (just_reset) begin
            checkOutput("rst_rsp_id", rsp_id, 0);
            checkOutput("rst_rsp_op", rsp_op, 0);
            checkOutput("rst_rsp_tag", rsp_tag, 0);
            checkOutput("rst_rsp_data", rsp_data, 0);
        end
        if (rst) begin
            exp_q.delete();
            m_ptr      = 0;
            just_reset = 1'b1;
            m_grants[0] = 0;
            m_grants[1] = 0;
            m_stalls   = 0;
        end else begin
            just_reset = 1'b0;
            if (full && !rsp_ready && (|req_valid)) m_stalls++;
            if (full && rsp_ready) void'(exp_q.pop_front());
            if (win >= 0) begin
                e.id   = 1'(win);
                e.op   = op[win];
                e.tag  = tag[win];
                e.data = refAlu(op[win], a[win], b[win]);
                exp_q.push_back(e);
                m_ptr = (win + 1) % 2;
                m_grants[win]++;
            end
        end
    endtask

    // Runs n cycles with the currently driven inputs.
    // Inputs are set at the falling edge, and outputs are sampled 1 unit later.
    task automatic applyStimulus(input int n);
        for (int c = 0; c < n; c++) begin
            #1;
            scoreCycle();
            @(negedge clk);
        end
    endtask

    // Directed sequence first, then a randomized phase, then reset during backpressure
    initial begin
        logic [4:0]  e_op [4];
        logic [31:0] e_a  [4];
        logic [31:0] e_b  [4];
        logic [31:0] e_r  [4];
        compared   = 0;
        mismatched = 0;
        m_ptr      = 0;
        just_reset = 1'b1;
        m_grants[0] = 0;
        m_grants[1] = 0;
        m_stalls   = 0;
        rst        = 1'b1;
        req_valid  = 2'b00;
        rsp_ready  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op[i] = '0; a[i] = '0; b[i] = '0; tag[i] = '0;
        end

        // Two reset cycles. The first edge brings the DUT out of X.
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1);
        rst = 1'b0;

        $display("[TB] idle after reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("idle_data", rsp_data, 0);
        end

        $display("[TB] single add");
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        op[0] = 5'b01101; a[0] = 32'd5; b[0] = 32'd7; tag[0] = 4'd3;
        applyStimulus(1);
        checkOutput("add_valid", rsp_valid, 1);
        checkOutput("add_data", rsp_data, 12);
        checkOutput("add_id", rsp_id, 0);
        checkOutput("add_tag", rsp_tag, 3);
        req_valid = 2'b00;
        applyStimulus(1);

        $display("[TB] contention");
        req_valid = 2'b11;
        op[0] = 5'b01110; a[0] = 32'd10; b[0] = 32'd3;    tag[0] = 4'd1;
        op[1] = 5'b01000; a[1] = 32'd1;  b[1] = 32'h24;   tag[1] = 4'd2;
        applyStimulus(4);

        $display("[TB] backpressure");
        req_valid = 2'b10;
        rsp_ready = 1'b0;
        applyStimulus(3);
        rsp_ready = 1'b1;
        applyStimulus(1);
        checkOutput("bp_id", rsp_id, 1);
        checkOutput("bp_data", rsp_data, 32'h10);
        req_valid = 2'b00;
        applyStimulus(1);

        $display("[TB] edge ops");
        e_op[0] = 5'b01001; e_a[0] = 32'h80000000; e_b[0] = 32'd31;        e_r[0] = 32'd1;
        e_op[1] = 5'b00110; e_a[1] = 32'hFFFF0000; e_b[1] = 32'h0F0F0F0F;  e_r[1] = 32'hF0F00F0F;
        e_op[2] = 5'b11111; e_a[2] = 32'h12345678; e_b[2] = 32'h9ABCDEF0;  e_r[2] = 32'd0;
        e_op[3] = 5'b10001; e_a[3] = 32'hFFFFFFFF; e_b[3] = 32'd1;         e_r[3] = 32'd0;
        req_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            op[0] = e_op[i]; a[0] = e_a[i]; b[0] = e_b[i]; tag[0] = 4'(i);
            applyStimulus(1);
            checkOutput("edge_valid", rsp_valid, 1);
            checkOutput("edge_data", rsp_data, e_r[i]);
        end
        req_valid = 2'b00;
        applyStimulus(1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 60; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = 1'($urandom_range(0, 1));
            for (int r = 0; r < 2; r++) begin
                op[r]  = 5'($urandom_range(0, 31));
                a[r]   = $urandom;
                b[r]   = $urandom;
                tag[r] = 4'($urandom_range(0, 15));
            end
            applyStimulus(1);
        end

        $display("[TB] reset while full");
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        applyStimulus(1);
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        applyStimulus(1);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        rsp_ready = 1'b1;
        checkOutput("rst_mid_valid", rsp_valid, 0);
`ifdef EX_ALU_ARB_PERF_EN
        checkOutput("rst_perf_grant", perf_grant_cnt, 0);
        checkOutput("rst_perf_stall", perf_stall_cnt, 0);
`endif
        #1;
        checkOutput("rst_ptr_ready", req_ready, 2'b01);
        applyStimulus(1);
        req_valid = 2'b00;
        applyStimulus(2);

`ifdef EX_ALU_ARB_PERF_EN
        checkOutput("perf_grant0", perf_grant_cnt[31:0], m_grants[0]);
        checkOutput("perf_grant1", perf_grant_cnt[63:32], m_grants[1]);
        checkOutput("perf_stall", perf_stall_cnt, m_stalls);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
